// File: rtl/trdb_packet_scheduler_pkg.sv
// Shared types and constants for the trace-encoder packet scheduler.
package trdb_packet_scheduler_pkg;

  localparam int unsigned BMAP_LEN     = 31;
  localparam int unsigned BRANCH_CNT_W = 5;

  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'h0,
    F_DIFF_DELTA = 2'h1,
    F_ADDR_ONLY  = 2'h2,
    F_SYNC       = 2'h3
  } trdb_format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'h0,
    SF_TRAP    = 2'h1,
    SF_CONTEXT = 2'h2,
    SF_RES     = 2'h3
  } trdb_f_sync_subformat_e;

  typedef enum logic [1:0] {
    SF_PBC  = 2'h0,
    SF_RES1 = 2'h1,
    SF_RES2 = 2'h2,
    SF_RES3 = 2'h3
  } trdb_f_opt_ext_subformat_e;

  typedef enum logic [1:0] {
    StIdle  = 2'h0,
    StStart = 2'h1,
    StRun   = 2'h2,
    StFlush = 2'h3
  } trdb_sched_state_e;

  typedef struct packed {
    trdb_format_e              format;
    logic [1:0]                subformat;
    logic [BRANCH_CNT_W-1:0]   branches;
    logic [BMAP_LEN-1:0]       bmap;
  } trdb_pkt_desc_t;

  // A completely full map is reported as a branch count of zero.
  function automatic logic [BRANCH_CNT_W-1:0] enc_branches(input logic [BRANCH_CNT_W-1:0] cnt);
    return (cnt == BRANCH_CNT_W'(BMAP_LEN)) ? '0 : cnt;
  endfunction

  function automatic trdb_pkt_desc_t mk_desc(input trdb_format_e fmt, input logic [1:0] sub,
                                             input logic [BRANCH_CNT_W-1:0] br,
                                             input logic [BMAP_LEN-1:0] map);
    trdb_pkt_desc_t d;
    d.format    = fmt;
    d.subformat = sub;
    d.branches  = br;
    d.bmap      = map;
    return d;
  endfunction

endpackage

// File: rtl/trdb_branch_map.sv
// Branch map accumulator: bit i holds ~taken of the i-th recorded branch.
module trdb_branch_map
  import trdb_packet_scheduler_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic                    taken_i,
  input  logic                    clear_i,
  output logic [BMAP_LEN-1:0]     map_o,
  output logic [BRANCH_CNT_W-1:0] count_o,
  output logic                    full_o
);

  logic [BMAP_LEN-1:0]     map_q, map_d;
  logic [BRANCH_CNT_W-1:0] count_q, count_d;

  always_comb begin
    map_d   = map_q;
    count_d = count_q;
    if (push_i) begin
      map_d[count_q] = ~taken_i;
      count_d        = count_q + BRANCH_CNT_W'(1);
    end
  end

  // Outputs include a branch pushed this cycle so a same-cycle packet carries it.
  assign map_o   = map_d;
  assign count_o = count_d;
  assign full_o  = (count_d == BRANCH_CNT_W'(BMAP_LEN));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_q   <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      map_q   <= '0;
      count_q <= '0;
    end else begin
      map_q   <= map_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/trdb_packet_scheduler.sv
// Per-retirement packet format scheduler: picks the packet type, tracks the branch
// map and resync counter, and hands one descriptor at a time to the payload builder.
module trdb_packet_scheduler
  import trdb_packet_scheduler_pkg::*;
#(
  parameter int unsigned BMAP_LEN = 31,
  parameter int unsigned RESYNC_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                retire_i,
  input  logic                is_branch_i,
  input  logic                taken_i,
  input  logic                trap_i,
  input  logic                ctx_change_i,
  input  logic                updiscon_i,
  input  logic [RESYNC_W-1:0] resync_period_i,
  output logic                pkt_valid_o,
  input  logic                pkt_ready_i,
  output logic [1:0]          pkt_format_o,
  output logic [1:0]          pkt_subformat_o,
  output logic [4:0]          pkt_branches_o,
  output logic [BMAP_LEN-1:0] pkt_bmap_o,
  output logic                stall_o,
  output logic                overflow_o
);

  trdb_sched_state_e       state_q, state_d;
  trdb_pkt_desc_t          desc_q, desc_d, diff_desc;
  trdb_f_sync_subformat_e  sync_sub_q, sync_sub_d, sync_sub;
  logic                    valid_q, valid_d;
  logic [RESYNC_W-1:0]     rcnt_q, rcnt_d;
  logic                    rpend_q, rpend_d;
  logic                    ovf_q, ovf_d;
  logic                    stall, out_free, sampled, period_hit, resync_pend, sync_ev;
  logic                    map_push, map_clear, map_full;
  logic [BMAP_LEN-1:0]     map_bits;
  logic [BRANCH_CNT_W-1:0] map_cnt;

  assign stall       = (valid_q & ~pkt_ready_i) | (state_q == StFlush);
  assign out_free    = ~valid_q | pkt_ready_i;
  assign sampled     = retire_i & ~stall;
  assign period_hit  = (resync_period_i != '0) && (rcnt_q == resync_period_i - RESYNC_W'(1));
  assign resync_pend = rpend_q | period_hit;
  assign sync_ev     = trap_i | resync_pend | ctx_change_i;
  assign sync_sub    = trap_i ? SF_TRAP : (resync_pend ? SF_START : SF_CONTEXT);
  assign map_push    = (state_q == StRun) & enable_i & sampled & is_branch_i;
  assign diff_desc   = mk_desc(F_DIFF_DELTA, 2'b00, enc_branches(map_cnt), map_bits);

  trdb_branch_map u_branch_map (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (map_push),
    .taken_i (taken_i),
    .clear_i (map_clear),
    .map_o   (map_bits),
    .count_o (map_cnt),
    .full_o  (map_full)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q & ~pkt_ready_i;
    desc_d     = desc_q;
    sync_sub_d = sync_sub_q;
    rcnt_d     = rcnt_q;
    rpend_d    = rpend_q | period_hit;
    ovf_d      = ovf_q | (retire_i & stall);
    map_clear  = 1'b0;
    case (state_q)
      StIdle: if (enable_i) state_d = StStart;
      StStart: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (sampled) begin
          valid_d   = 1'b1;
          desc_d    = mk_desc(F_SYNC, SF_START, '0, '0);
          map_clear = 1'b1;
          rcnt_d    = '0;
          rpend_d   = 1'b0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (!enable_i) begin
          // Drain a non-empty map before going idle; wait for the output slot if busy.
          if (map_cnt == '0) begin
            state_d = StIdle;
          end else if (out_free) begin
            valid_d   = 1'b1;
            desc_d    = diff_desc;
            map_clear = 1'b1;
            state_d   = StIdle;
          end
        end else if (sampled) begin
          if (resync_period_i != '0 && rcnt_q != '1) rcnt_d = rcnt_q + RESYNC_W'(1);
          if (sync_ev) begin
            map_clear = 1'b1;
            valid_d   = 1'b1;
            if (map_cnt != '0) begin
              desc_d     = diff_desc;
              sync_sub_d = sync_sub;
              state_d    = StFlush;
            end else begin
              desc_d = mk_desc(F_SYNC, sync_sub, '0, '0);
              if (sync_sub == SF_START) begin
                rcnt_d  = '0;
                rpend_d = 1'b0;
              end
            end
          end else if (updiscon_i) begin
            map_clear = 1'b1;
            valid_d   = 1'b1;
            desc_d    = (map_cnt != '0) ? diff_desc : mk_desc(F_ADDR_ONLY, 2'b00, '0, '0);
          end else if (map_full) begin
            map_clear = 1'b1;
            valid_d   = 1'b1;
            desc_d    = diff_desc;
          end
        end
      end
      StFlush: begin
        if (out_free) begin
          valid_d = 1'b1;
          desc_d  = mk_desc(F_SYNC, sync_sub_q, '0, '0);
          if (sync_sub_q == SF_START) begin
            rcnt_d  = '0;
            rpend_d = 1'b0;
          end
          state_d = enable_i ? StRun : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StIdle && state_q != StIdle) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      desc_q     <= '0;
      sync_sub_q <= SF_START;
      rcnt_q     <= '0;
      rpend_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      desc_q     <= desc_d;
      sync_sub_q <= sync_sub_d;
      rcnt_q     <= rcnt_d;
      rpend_q    <= rpend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pkt_valid_o     = valid_q;
  assign pkt_format_o    = desc_q.format;
  assign pkt_subformat_o = desc_q.subformat;
  assign pkt_branches_o  = desc_q.branches;
  assign pkt_bmap_o      = desc_q.bmap;
  assign stall_o         = stall;
  assign overflow_o      = ovf_q;

endmodule

// File: doc/trdb_packet_scheduler.md
Name: trdb_packet_scheduler

Overview:
- Per-retirement packet-format scheduler for the trace encoder.
- Observes retired-instruction events and decides which packet to emit: format (F_OPT_EXT/F_DIFF_DELTA/F_ADDR_ONLY/F_SYNC) and subformat.
- Accumulates the branch map and runs the resync counter.
- Hands one packet descriptor per cycle to the payload builder over a valid/ready channel; back-pressures the retirement interface when needed.

Parameters:
- BMAP_LEN, 31, branch map capacity in branches.
- RESYNC_W, 16, width of resync counter and period.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  tracing enabled.
- retire_i  in  1  one instruction retired this cycle; sampled only when stall_o=0.
- is_branch_i  in  1  retired instr is a conditional branch.
- taken_i  in  1  branch taken.
- trap_i  in  1  retired instr took exception/interrupt.
- ctx_change_i  in  1  privilege/context changed.
- updiscon_i  in  1  uninferable discontinuity (indirect jump).
- resync_period_i  in  RESYNC_W  retirements between resync; 0 disables.
- pkt_valid_o  out  1  descriptor valid.
- pkt_ready_i  in  1  builder accepts.
- pkt_format_o  out  2  trdb_format_e.
- pkt_subformat_o  out  2  trdb_f_sync_subformat_e when F_SYNC, else 0.
- pkt_branches_o  out  5  branch count; 0 with F_DIFF_DELTA means full map.
- pkt_bmap_o  out  BMAP_LEN  branch map; bit i = ~taken of i-th branch.
- stall_o  out  1  upstream must hold retire_i/events.
- overflow_o  out  1  sticky: event presented while stall_o=1.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, map 0.
- States:
  - IDLE: enable_i=0.
  - START: enabled, awaiting first retire.
  - RUN: normal tracing.
  - FLUSH: map emitted, sync packet pending.
- Transitions:
  - IDLE→START on enable_i=1.
  - START→RUN on first sampled retire: emit F_SYNC/SF_START, clear map and resync counter.
  - RUN, enable_i falls: if count>0, emit F_DIFF_DELTA carrying the map; go to IDLE.
- Branch recording: a branch retiring in the same cycle as an event is appended to the map first, so the emitted packet includes it.
- Event priority in RUN (one packet per sampled retire, highest first):
  1. trap_i → F_SYNC/SF_TRAP.
  2. resync_pend → F_SYNC/SF_START.
  3. ctx_change_i → F_SYNC/SF_CONTEXT.
  4. updiscon_i → F_DIFF_DELTA if count>0, else F_ADDR_ONLY.
  5. count reaches BMAP_LEN → F_DIFF_DELTA, pkt_branches_o=0.
  6. Otherwise no packet.
- Sync with non-empty map:
  - Emit F_DIFF_DELTA with the map first and latch the sync subformat.
  - Go to FLUSH and assert stall_o.
  - Next accepted handshake emits the latched F_SYNC, then return to RUN.
  - Lower-priority events in the same cycle are dropped; F_SYNC supersedes them.
- Map and count clear on every emitted F_SYNC/F_DIFF_DELTA/F_ADDR_ONLY.
- Resync counter:
  - Increments per sampled retire.
  - When it equals resync_period_i-1, set resync_pend.
  - Clears when SF_START is emitted.
  - Saturates at max; inert when period=0.
- Output register (single entry):
  - pkt_valid_o holds until pkt_ready_i; fields stable while valid & !ready.
  - stall_o = (pkt_valid_o & ~pkt_ready_i) | (state==FLUSH).
  - Latency: descriptor registered 1 cycle after the sampled retire.
- overflow_o:
  - Set when retire_i=1 while stall_o=1; the event is ignored.
  - Cleared only on transition to IDLE or reset.
- enable_i falling while in FLUSH: finish emitting the pending sync, then go to IDLE.
- Asynchronous reset mid-packet: drop everything immediately.

Decomposition:
- Shared package holds trdb_format_e, trdb_f_sync_subformat_e, trdb_f_opt_ext_subformat_e, plus new typedefs:
  - trdb_sched_state_e.
  - trdb_pkt_desc_t struct: format, subformat, branches, bmap.
  - BMAP_LEN and BRANCH_CNT_W constants.
- One sub-module: trdb_branch_map (shift-in map, count, full flag, synchronous clear).

Test Plan:
- Enable, 3 plain retires → first: F_SYNC/SF_START, branches=0; then no packets; stall_o=0 throughout.
- After start, branches taken,not,taken, then updiscon → F_DIFF_DELTA, branches=3, bmap[2:0]=3'b010.
- 31 consecutive branches, no events → F_DIFF_DELTA, branches=0, bmap=all ~taken values; next branch starts count at 1.
- 2 branches then trap → F_DIFF_DELTA (branches=2), stall_o=1 one cycle, then F_SYNC/SF_TRAP; retire during stall sets overflow_o.
- resync_period_i=4, 4 retires after start → 4th yields F_SYNC/SF_START; with period 0, no resync after 100 retires.
- Hold pkt_ready_i=0 for 5 cycles with valid packet → fields stable, stall_o=1; assert rst_ni=0 mid-hold → all outputs 0 the same cycle.
